// File: rtl/req_demux.sv
// req_demux: routes one master memory request to one of four slave ports
// (0 data memory, 1 timer 0, 2 timer 1, 3 interrupt generator) selected by
// m_addr[SEL_LO+1:SEL_LO], and returns read data from the selected slave only.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   m_valid/m_ready                 master request handshake
//   m_addr/m_we/m_byteen/m_wdata    master request payload
//   m_rdata/m_rvalid                registered read return (one-cycle pulse)
//   m_err                           registered timeout pulse
//   s_valid[3:0]                    one-hot slave request
//   s_ready[3:0]                    per-slave accept
//   s_addr/s_we/s_byteen/s_wdata    shared slave request payload
//   s_rdata[127:0]/s_rvalid[3:0]    per-slave read data, slave k at [32k+31:32k]
//
// Optional feature macro: REQ_DEMUX_TIMEOUT_EN
//   defined   -> per-transaction cycle budget of TIMEOUT_CYC; on expiry return
//                to IDLE, pulse m_err (and m_rvalid with 32'hDEAD_BEEF on reads)
//   undefined -> waits indefinitely, m_err stays 0
module req_demux #(
    parameter int unsigned SEL_LO      = 4,
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned AW   = 32,
    localparam int unsigned DW   = 32,
    localparam int unsigned BEW  = 4,
    localparam int unsigned NSLV = 4,
    localparam int unsigned SELW = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               m_valid,
    output logic               m_ready,
    input  logic [AW-1:0]      m_addr,
    input  logic               m_we,
    input  logic [BEW-1:0]     m_byteen,
    input  logic [DW-1:0]      m_wdata,
    output logic [DW-1:0]      m_rdata,
    output logic               m_rvalid,
    output logic               m_err,
    output logic [NSLV-1:0]    s_valid,
    input  logic [NSLV-1:0]    s_ready,
    output logic [AW-1:0]      s_addr,
    output logic               s_we,
    output logic [BEW-1:0]     s_byteen,
    output logic [DW-1:0]      s_wdata,
    input  logic [NSLV*DW-1:0] s_rdata,
    input  logic [NSLV-1:0]    s_rvalid
);

    // Elaboration-time parameter sanity checks.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("req_demux: TIMEOUT_CYC must be in 1..255");
    end
    if (SEL_LO + SELW > AW) begin : g_bad_sel_lo
        $error("req_demux: select field exceeds address width");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SELW-1:0]   sel;
    logic [SELW-1:0]   sel_nxt;
    logic [AW-1:0]     addr_nxt;
    logic              we_nxt;
    logic [BEW-1:0]    byteen_nxt;
    logic [DW-1:0]     wdata_nxt;
    logic [NSLV-1:0]   valid_nxt;
    logic              ready_nxt;
    logic [DW-1:0]     rdata_nxt;
    logic              rvalid_nxt;
    logic              err_nxt;

    // Handshake signals of the currently selected slave; others are ignored.
    logic              tgt_ready;
    logic              tgt_rvalid;
    logic [DW-1:0]     tgt_rdata;
    logic [SELW-1:0]   req_sel;

    assign tgt_ready  = s_ready[sel];
    assign tgt_rvalid = s_rvalid[sel];
    assign tgt_rdata  = s_rdata[DW*32'(sel) +: DW];
    assign req_sel    = m_addr[SEL_LO +: SELW];

`ifdef REQ_DEMUX_TIMEOUT_EN
    localparam int unsigned CW = 8;
    localparam logic [DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Transaction cycle counter: cleared on accept, counts ISSUE/RESP cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        addr_nxt   = s_addr;
        we_nxt     = s_we;
        byteen_nxt = s_byteen;
        wdata_nxt  = s_wdata;
        valid_nxt  = s_valid;
        rdata_nxt  = m_rdata;
        rvalid_nxt = 1'b0;
        err_nxt    = 1'b0;
`ifdef REQ_DEMUX_TIMEOUT_EN
        cnt_nxt    = cnt;
`endif

        unique case (state)
            IDLE: begin
                if (m_valid) begin
                    addr_nxt   = m_addr;
                    we_nxt     = m_we;
                    byteen_nxt = m_byteen;
                    wdata_nxt  = m_wdata;
                    sel_nxt    = req_sel;
                    valid_nxt  = NSLV'(1) << req_sel;
                    state_nxt  = ISSUE;
`ifdef REQ_DEMUX_TIMEOUT_EN
                    cnt_nxt    = '0;
`endif
                end
            end
            ISSUE: begin
                if (tgt_ready) begin
                    valid_nxt = '0;
                    state_nxt = s_we ? IDLE : RESP;
                end
            end
            RESP: begin
                if (tgt_rvalid) begin
                    rdata_nxt  = tgt_rdata;
                    rvalid_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                valid_nxt = '0;
                state_nxt = IDLE;
            end
        endcase

`ifdef REQ_DEMUX_TIMEOUT_EN
        // A completing write or read-data return beats an expiring budget.
        if (state == ISSUE || state == RESP) begin
            cnt_nxt = cnt + CW'(1);
            if (state_nxt != IDLE && cnt == CW'(TIMEOUT_CYC)) begin
                valid_nxt = '0;
                err_nxt   = 1'b1;
                state_nxt = IDLE;
                if (!s_we) begin
                    rvalid_nxt = 1'b1;
                    rdata_nxt  = TIMEOUT_RDATA;
                end
            end
        end
`endif

        ready_nxt = (state_nxt == IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs and latched request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel      <= '0;
            s_addr   <= '0;
            s_we     <= 1'b0;
            s_byteen <= '0;
            s_wdata  <= '0;
            s_valid  <= '0;
            m_ready  <= 1'b1;
            m_rdata  <= '0;
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            sel      <= sel_nxt;
            s_addr   <= addr_nxt;
            s_we     <= we_nxt;
            s_byteen <= byteen_nxt;
            s_wdata  <= wdata_nxt;
            s_valid  <= valid_nxt;
            m_ready  <= ready_nxt;
            m_rdata  <= rdata_nxt;
            m_rvalid <= rvalid_nxt;
            m_err    <= err_nxt;
        end
    end

endmodule
